wb_conbus_rr: RTL and testbench



---
 rtl/wb_conbus_pkg.sv | 39 +++
 rtl/wb_rr_arbiter.sv | 71 +++++++
 rtl/wb_conbus_rr.sv | 142 ++++++++++++++
 tb/tb_wb_conbus_rr.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_conbus_pkg.sv
// Shared Wishbone types and constants for the LM32 shared-bus interconnect.
// Holds the CTI/BTE encodings, bus structs and the default 8-slave address map.
package wb_conbus_pkg;

    localparam logic [2:0] CTI_CLASSIC     = 3'b000;
    localparam logic [2:0] CTI_CONST_BURST = 3'b001;
    localparam logic [2:0] CTI_INC_BURST   = 3'b010;
    localparam logic [2:0] CTI_END_BURST   = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        cyc;
        logic        stb;
    } wb_m2s_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        ack;
        logic        err;
    } wb_s2m_t;

    localparam int unsigned DEF_NS       = 8;
    localparam int unsigned DEF_S_ADDR_W = 3;
    localparam logic [23:0] DEF_S_ADDR   = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    // Index width for n items, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Registered round-robin bus arbiter: a master keeps the bus while its cyc is high,
// then ownership passes to the next requester after the last owner.
module wb_rr_arbiter
    import wb_conbus_pkg::*;
#(
    parameter int unsigned NM = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NM-1:0] req_i,
    output logic [NM-1:0] gnt_o
);

    localparam int unsigned GW = idx_w(NM);

    typedef enum logic {StIdle, StOwned} state_e;

    state_e        state_q;
    logic [GW-1:0] g_q, rr_q, pick;
    logic [NM-1:0] gnt_q, pick_oh;
    int unsigned   best;

    // Rank requesters by distance past rr_q; rr_q itself ranks last.
    always_comb begin
        best = NM;
        pick = rr_q;
        for (int unsigned i = 0; i < NM; i++) begin
            if (req_i[i] && (((i + NM - 1 - 32'(rr_q)) % NM) < best)) begin
                best = (i + NM - 1 - 32'(rr_q)) % NM;
                pick = GW'(i);
            end
        end
    end

    assign pick_oh = NM'(1) << pick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            g_q     <= '0;
            rr_q    <= GW'(NM - 1);
            gnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_i) begin
                        state_q <= StOwned;
                        g_q     <= pick;
                        rr_q    <= pick;
                        gnt_q   <= pick_oh;
                    end
                end
                StOwned: begin
                    if (!req_i[g_q]) begin
                        if (|req_i) begin
                            g_q   <= pick;
                            rr_q  <= pick;
                            gnt_q <= pick_oh;
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign gnt_o = gnt_q;

endmodule

// File: rtl/wb_conbus_rr.sv
// Parametrised Wishbone shared-bus interconnect: round-robin arbitration, address decode
// with per-slave enables, and an error responder for unmapped or stalled accesses.
module wb_conbus_rr
    import wb_conbus_pkg::*;
#(
    parameter int unsigned             NM       = 2,
    parameter int unsigned             NS       = DEF_NS,
    parameter int unsigned             S_ADDR_W = DEF_S_ADDR_W,
    parameter logic [NS*S_ADDR_W-1:0]  S_ADDR   = DEF_S_ADDR,
    parameter logic [NS-1:0]           S_EN     = '1,
    parameter int unsigned             TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM*32-1:0] m_adr_i,
    input  logic [NM*32-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    output logic [31:0]      m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic             s_we_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    input  logic [NS*32-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i,
    input  logic [NS-1:0]    s_err_i,
    output logic [NM-1:0]    gnt_o
);

    localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [NM-1:0]  gnt;
    logic           owned, hit;
    wb_m2s_t        own;
    wb_s2m_t        rsp;
    logic [NS-1:0]  sel_oh;
    logic           req_act, unmap_hit, wd_run, wd_fire;
    logic           err_q, err_d;
    logic [WDW-1:0] wd_q, wd_d;

    wb_rr_arbiter #(
        .NM (NM)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (m_cyc_i),
        .gnt_o (gnt)
    );

    assign owned = |gnt;

    // Owner mux; an empty grant leaves every field at zero.
    always_comb begin
        own = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (gnt[i]) begin
                own.adr = m_adr_i[i*32 +: 32];
                own.dat = m_dat_i[i*32 +: 32];
                own.sel = m_sel_i[i*4 +: 4];
                own.we  = m_we_i[i];
                own.cyc = m_cyc_i[i];
                own.stb = m_stb_i[i];
            end
        end
    end

    // Descending scan so the lowest matching enabled slave wins.
    always_comb begin
        sel_oh = '0;
        for (int i = int'(NS) - 1; i >= 0; i--) begin
            if (S_EN[i] && (own.adr[31 -: S_ADDR_W] == S_ADDR[i*S_ADDR_W +: S_ADDR_W])) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
        if (!owned) begin
            sel_oh = '0;
        end
    end

    assign hit = |sel_oh;

    always_comb begin
        rsp = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            if (sel_oh[i]) begin
                rsp.dat = s_dat_i[i*32 +: 32];
                rsp.ack = s_ack_i[i];
                rsp.err = s_err_i[i];
            end
        end
    end

    // A handoff only happens when the old owner's cyc is low, so req_act drops and
    // the watchdog clears on every owner change.
    assign req_act   = owned && own.cyc && own.stb;
    assign unmap_hit = req_act && !hit && !err_q;
    assign wd_run    = req_act && hit && !rsp.ack && !rsp.err && !err_q;

    always_comb begin
        wd_fire = 1'b0;
        wd_d    = '0;
        if (TIMEOUT > 0 && wd_run) begin
            if (wd_q >= WDW'(TIMEOUT)) begin
                wd_fire = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    assign err_d = unmap_hit || wd_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign s_adr_o = own.adr;
    assign s_dat_o = own.dat;
    assign s_sel_o = own.sel;
    assign s_we_o  = own.we;
    assign s_cyc_o = own.cyc ? sel_oh : '0;
    assign s_stb_o = (own.cyc && own.stb) ? sel_oh : '0;

    assign m_dat_o = rsp.dat;
    assign m_ack_o = rsp.ack ? gnt : '0;
    assign m_err_o = (rsp.err || err_q) ? gnt : '0;
    assign gnt_o   = gnt;

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Bench for wb_conbus_rr: directed scenarios plus a random phase, every cycle compared
// against a transaction-level reference model of the arbiter, decoder and error responder.
module tb_wb_conbus_rr;

    localparam int unsigned NM = 3;
    localparam int unsigned NS = 8;
    localparam int unsigned T  = 4;
    localparam logic [NS-1:0] SEN = 8'b0111_1111;

    logic             clk = 1'b0;
    logic             rst;
    logic [NM*32-1:0] m_adr, m_dat;
    logic [NM*4-1:0]  m_sel;
    logic [NM-1:0]    m_we, m_cyc, m_stb;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, gnt_o;
    logic [31:0]      s_adr_o, s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o;
    logic [NS*32-1:0] s_dat;
    logic [NS-1:0]    s_ack, s_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: owner (-1 when idle), last owner, cycles waited, pending error.
    int mo_owner, mo_last, mo_wait;
    bit mo_err;

    always #5 clk = ~clk;

    wb_conbus_rr #(
        .NM      (NM),
        .NS      (NS),
        .S_EN    (SEN),
        .TIMEOUT (T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_we_i  (m_we),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat),
        .s_ack_i (s_ack),
        .s_err_i (s_err),
        .gnt_o   (gnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] adr);
        for (int i = 0; i < NS; i++) begin
            if (SEN[i] && adr[31:29] == 3'(i)) return i;
        end
        return -1;
    endfunction

    function automatic int next_owner();
        for (int k = 1; k <= NM; k++) begin
            if (m_cyc[(mo_last + k) % NM]) return (mo_last + k) % NM;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mo_owner = -1;
        mo_last  = NM - 1;
        mo_wait  = 0;
        mo_err   = 1'b0;
    endtask

    task automatic model_check();
        int            s;
        logic [NM-1:0] oh;
        logic [31:0]   e_adr, e_wdat, e_rdat;
        logic [3:0]    e_sel;
        logic          e_we;
        logic [NS-1:0] e_scyc, e_sstb;
        bit            cyc, stb, ack, serr;
        s = -1; oh = '0; e_adr = '0; e_wdat = '0; e_rdat = '0; e_sel = '0; e_we = 1'b0;
        e_scyc = '0; e_sstb = '0; cyc = 0; stb = 0; ack = 0; serr = 0;
        if (mo_owner >= 0) begin
            oh[mo_owner] = 1'b1;
            e_adr  = m_adr[mo_owner*32 +: 32];
            e_wdat = m_dat[mo_owner*32 +: 32];
            e_sel  = m_sel[mo_owner*4 +: 4];
            e_we   = m_we[mo_owner];
            cyc    = m_cyc[mo_owner];
            stb    = m_stb[mo_owner];
            s      = decode(e_adr);
        end
        if (s >= 0) begin
            ack    = s_ack[s];
            serr   = s_err[s];
            e_rdat = s_dat[s*32 +: 32];
            if (cyc) e_scyc[s] = 1'b1;
            if (cyc && stb) e_sstb[s] = 1'b1;
        end
        chk("gnt_o", 32'(gnt_o), 32'(oh));
        chk("s_adr_o", s_adr_o, e_adr);
        chk("s_dat_o", s_dat_o, e_wdat);
        chk("s_sel_o", 32'(s_sel_o), 32'(e_sel));
        chk("s_we_o", 32'(s_we_o), 32'(e_we));
        chk("s_cyc_o", 32'(s_cyc_o), 32'(e_scyc));
        chk("s_stb_o", 32'(s_stb_o), 32'(e_sstb));
        chk("m_dat_o", m_dat_o, e_rdat);
        chk("m_ack_o", 32'(m_ack_o), ack ? 32'(oh) : 32'd0);
        chk("m_err_o", 32'(m_err_o), (serr || mo_err) ? 32'(oh) : 32'd0);
    endtask

    // Advance the model across one clock edge using the inputs held during that cycle.
    task automatic model_update();
        int s, w;
        bit act, ack, serr, nxt_err;
        s = -1; act = 0; ack = 0; serr = 0; nxt_err = 0;
        if (mo_owner >= 0) begin
            s   = decode(m_adr[mo_owner*32 +: 32]);
            act = m_cyc[mo_owner] && m_stb[mo_owner];
            if (s >= 0) begin
                ack  = s_ack[s];
                serr = s_err[s];
            end
        end
        if (act && s < 0 && !mo_err) nxt_err = 1;
        if (act && s >= 0 && !ack && !serr && !mo_err) begin
            if (mo_wait == T) begin
                nxt_err = 1;
                mo_wait = 0;
            end else begin
                mo_wait++;
            end
        end else begin
            mo_wait = 0;
        end
        mo_err = nxt_err;
        if (mo_owner < 0 || !m_cyc[mo_owner]) begin
            w = next_owner();
            mo_owner = w;
            if (w >= 0) mo_last = w;
        end
    endtask

    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        if (rst) model_update();
        else model_reset();
        #1;
    endtask

    task automatic clr_all();
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        s_dat = '0; s_ack = '0; s_err = '0;
    endtask

    task automatic set_m(input int i, input bit we, input logic [31:0] adr);
        m_cyc[i] = 1'b1;
        m_stb[i] = 1'b1;
        m_we[i]  = we;
        m_adr[i*32 +: 32] = adr;
        m_dat[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        m_sel[i*4 +: 4]   = 4'hf;
    endtask

    initial begin
        bit quiet;
        quiet = 0;
        rst = 1'b1;
        clr_all();
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_stb", 32'(s_stb_o), 32'd0);
        chk("rst_ack", 32'(m_ack_o), 32'd0);
        #10 rst = 1'b1;
        step();

        // Single read from slave 1 with a zero-wait ack.
        set_m(0, 0, 32'h2000_0004);
        s_dat[32 +: 32] = 32'hDEAD_BEEF;
        s_ack[1] = 1'b1;
        #1 chk("rd_idle_stb", 32'(s_stb_o), 32'd0);
        step();
        #1;
        chk("rd_stb", 32'(s_stb_o), 32'h02);
        chk("rd_dat", m_dat_o, 32'hDEAD_BEEF);
        chk("rd_ack", 32'(m_ack_o), 32'b001);
        chk("rd_gnt", 32'(gnt_o), 32'b001);
        step();

        // Asynchronous reset in the middle of the access.
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_cyc", 32'(s_cyc_o), 32'd0);
        chk("mid_rst_stb", 32'(s_stb_o), 32'd0);
        chk("mid_rst_ack", 32'(m_ack_o), 32'd0);
        chk("mid_rst_gnt", 32'(gnt_o), 32'd0);
        model_reset();
        clr_all();
        @(posedge clk);
        #2 rst = 1'b1;
        step();

        // Contention: M0 first after reset, direct handoff, then back to M0.
        set_m(0, 0, 32'h4000_0000);
        set_m(1, 0, 32'h8000_0000);
        step();
        #1 chk("cont_first", 32'(gnt_o), 32'b001);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        step();
        #1 chk("cont_handoff", 32'(gnt_o), 32'b010);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        step();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        step();
        #1 chk("cont_rotate", 32'(gnt_o), 32'b001);
        clr_all();
        step();
        step();

        // Unmapped write (slave 7 disabled): single error pulse one cycle after stb.
        set_m(1, 1, 32'hE000_0000);
        step();
        #1;
        chk("unm_gnt", 32'(gnt_o), 32'b010);
        chk("unm_stb", 32'(s_stb_o), 32'd0);
        chk("unm_err0", 32'(m_err_o), 32'd0);
        step();
        #1 chk("unm_err1", 32'(m_err_o), 32'b010);
        m_stb[1] = 1'b0;
        step();
        #1 chk("unm_err2", 32'(m_err_o), 32'd0);
        clr_all();
        step();

        // Watchdog on slave 3: error exactly T+1 cycles after stb.
        set_m(0, 0, 32'h6000_0000);
        step();
        for (int k = 0; k < 7; k++) begin
            #1 chk("wd_err", 32'(m_err_o), (k == 5) ? 32'b001 : 32'd0);
            step();
        end
        m_stb[0] = 1'b0;
        step();
        m_stb[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("wd_wait_ack", 32'(m_ack_o), 32'd0);
            step();
        end
        s_ack[3] = 1'b1;
        #1;
        chk("wd_late_ack", 32'(m_ack_o), 32'b001);
        chk("wd_late_noerr", 32'(m_err_o), 32'd0);
        step();
        s_ack[3] = 1'b0;
        m_stb[0] = 1'b0;
        #1 chk("wd_after_ack", 32'(m_err_o), 32'd0);
        step();
        clr_all();
        step();

        // Burst: M0 keeps cyc over three beats while M1 waits.
        set_m(0, 0, 32'h0000_0010);
        s_ack[0] = 1'b1;
        step();
        set_m(1, 0, 32'h8000_0000);
        for (int b = 0; b < 3; b++) begin
            #1;
            chk("burst_gnt", 32'(gnt_o), 32'b001);
            chk("burst_ack", 32'(m_ack_o), 32'b001);
            step();
        end
        m_stb[0] = 1'b0;
        #1 chk("burst_hold", 32'(gnt_o), 32'b001);
        step();
        m_cyc[0] = 1'b0;
        step();
        #1 chk("burst_next", 32'(gnt_o), 32'b010);
        clr_all();
        step();
        step();

        // Random traffic, checked every cycle against the model.
        for (int n = 0; n < 2500; n++) begin
            if (n % 50 == 0) quiet = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NM; i++) begin
                if (m_cyc[i]) begin
                    if ($urandom_range(0, 7) == 0) m_cyc[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    m_cyc[i] = 1'b1;
                    m_adr[i*32 +: 32] = $urandom;
                end
                m_stb[i] = m_cyc[i] && ($urandom_range(0, 3) != 0);
                m_we[i]  = 1'($urandom_range(0, 1));
                m_dat[i*32 +: 32] = $urandom;
                m_sel[i*4 +: 4]   = 4'($urandom);
            end
            for (int j = 0; j < NS; j++) begin
                s_dat[j*32 +: 32] = $urandom;
                s_ack[j] = !quiet && ($urandom_range(0, 2) == 0);
                s_err[j] = !quiet && ($urandom_range(0, 15) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
